// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered, the ALU settles for one cycle, and the result returns on the winner's channel.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_z,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_z,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             owner_r;
    logic             last_grant_r;
    logic [OPW-1:0]   alu_op_r;
    logic [WIDTH-1:0] alu_x_r;
    logic [WIDTH-1:0] alu_y_r;
    logic [WIDTH-1:0] resp_z_r;
    logic             resp0_valid_r;
    logic             resp1_valid_r;
    logic             busy_r;

    logic             grant0_s;
    logic             grant1_s;
    logic             idle_s;
    logic             owner_ready_s;

    // Round-robin grant: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Ready is suppressed while reset is held so every output reads 0 during reset.
    assign idle_s        = (state_r == ST_IDLE) && rst_n;
    assign req0_ready    = idle_s & grant0_s;
    assign req1_ready    = idle_s & grant1_s;
    assign owner_ready_s = owner_r ? resp1_ready : resp0_ready;

    // Control FSM with operand, result and response-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            alu_op_r      <= {OPW{1'b0}};
            alu_x_r       <= {WIDTH{1'b0}};
            alu_y_r       <= {WIDTH{1'b0}};
            resp_z_r      <= {WIDTH{1'b0}};
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req1_ready) begin
                        alu_op_r     <= req1_op;
                        alu_x_r      <= req1_x;
                        alu_y_r      <= req1_y;
                        owner_r      <= 1'b1;
                        last_grant_r <= 1'b1;
                        state_r      <= ST_EXEC;
                        busy_r       <= 1'b1;
                    end else if (req0_ready) begin
                        alu_op_r     <= req0_op;
                        alu_x_r      <= req0_x;
                        alu_y_r      <= req0_y;
                        owner_r      <= 1'b0;
                        last_grant_r <= 1'b0;
                        state_r      <= ST_EXEC;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    resp_z_r      <= alu_z;
                    resp0_valid_r <= ~owner_r;
                    resp1_valid_r <= owner_r;
                    state_r       <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready_s) begin
                        resp0_valid_r <= 1'b0;
                        resp1_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_RESP;
                    end
                end
                default: begin
                    resp0_valid_r <= 1'b0;
                    resp1_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op      = alu_op_r;
    assign alu_x       = alu_x_r;
    assign alu_y       = alu_y_r;
    assign resp_z      = resp_z_r;
    assign resp0_valid = resp0_valid_r;
    assign resp1_valid = resp1_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;
    localparam int WIDTH = 16;
    localparam int OPW   = 5;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
    logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [WIDTH-1:0] resp_z;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_x, alu_y, alu_z;
    logic             busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Pending request per requester and the model's memory of the last winner.
    bit               pend_v[2];
    logic [OPW-1:0]   pend_op[2];
    logic [WIDTH-1:0] pend_x[2];
    logic [WIDTH-1:0] pend_y[2];
    int               model_last;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_z(resp_z), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
        .alu_z(alu_z), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [OPW-1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (op)
            5'd0:    return x + y;
            5'd1:    return x - y;
            5'd2:    return x & y;
            5'd3:    return x | y;
            5'd4:    return x ^ y;
            5'd5:    return ~x;
            5'd6:    return x << 1;
            5'd7:    return x >> 1;
            default: return x;
        endcase
    endfunction

    // The ALU the arbiter drives.
    assign alu_z = alu_ref(alu_op, alu_x, alu_y);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        req0_valid = pend_v[0]; req0_op = pend_op[0]; req0_x = pend_x[0]; req0_y = pend_y[0];
        req1_valid = pend_v[1]; req1_op = pend_op[1]; req1_x = pend_x[1]; req1_y = pend_y[1];
    endtask

    task automatic set_req(input int r, input logic [OPW-1:0] op,
                           input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        pend_v[r] = 1'b1; pend_op[r] = op; pend_x[r] = x; pend_y[r] = y;
    endtask

    task automatic rand_req(input int r);
        set_req(r, 5'($urandom_range(0, 9)), 16'($urandom), 16'($urandom));
    endtask

    // One full transaction, entered and left on a falling edge with the FSM idle.
    task automatic serve_one(input int stall, input bit refill, output logic [WIDTH-1:0] got_z);
        int               w;
        logic [OPW-1:0]   eop;
        logic [WIDTH-1:0] ex, ey, ez, hz;
        drive_reqs();
        #1;
        if (pend_v[0] && pend_v[1]) w = (model_last == 0) ? 1 : 0;
        else if (pend_v[0])         w = 0;
        else                        w = 1;
        check_eq("req0_ready_grant", req0_ready, w == 0);
        check_eq("req1_ready_grant", req1_ready, w == 1);
        eop = pend_op[w]; ex = pend_x[w]; ey = pend_y[w];
        ez = alu_ref(eop, ex, ey);
        @(posedge clk);
        @(negedge clk);
        model_last = w;
        pend_v[w]  = 1'b0;
        if (refill && !pend_v[1-w]) rand_req(1 - w);
        drive_reqs();
        #1;
        check_eq("exec_busy", busy, 1'b1);
        check_eq("exec_alu_op", alu_op, eop);
        check_eq("exec_alu_x", alu_x, ex);
        check_eq("exec_alu_y", alu_y, ey);
        check_eq("exec_ready", {req0_ready, req1_ready}, 2'b00);
        check_eq("exec_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check_eq("resp0_valid", resp0_valid, w == 0);
        check_eq("resp1_valid", resp1_valid, w == 1);
        check_eq("resp_z", resp_z, ez);
        got_z = resp_z;
        hz    = resp_z;
        for (int s = 0; s < stall; s++) begin
            if (w == 0) begin resp0_ready = 1'b0; resp1_ready = 1'($urandom_range(0, 1)); end
            else        begin resp1_ready = 1'b0; resp0_ready = 1'($urandom_range(0, 1)); end
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_resp_valid", {resp0_valid, resp1_valid}, (w == 0) ? 2'b10 : 2'b01);
            check_eq("stall_resp_z", resp_z, hz);
            check_eq("stall_alu_x", alu_x, ex);
            check_eq("stall_busy", busy, 1'b1);
            check_eq("stall_ready", {req0_ready, req1_ready}, 2'b00);
        end
        resp0_ready = (w == 0);
        resp1_ready = (w == 1);
        @(posedge clk);
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        check_eq("done_busy", busy, 1'b0);
        check_eq("done_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}, 5'b0);
        check_eq(tag, {resp_z, alu_x}, 32'h0);
        check_eq(tag, {alu_y, 11'b0, alu_op}, 32'h0);
    endtask

    typedef struct {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
    } vec_t;

    vec_t vecs[9];
    logic [WIDTH-1:0] z;

    initial begin
        vecs[0] = '{5'd0, 16'h0003, 16'h0004, 16'h0007};
        vecs[1] = '{5'd1, 16'h0010, 16'h0001, 16'h000F};
        vecs[2] = '{5'd0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[3] = '{5'd2, 16'hF0F0, 16'h0FF0, 16'h00F0};
        vecs[4] = '{5'd3, 16'hF000, 16'h000F, 16'hF00F};
        vecs[5] = '{5'd4, 16'hAAAA, 16'hFFFF, 16'h5555};
        vecs[6] = '{5'd5, 16'h00FF, 16'h1234, 16'hFF00};
        vecs[7] = '{5'd6, 16'h8001, 16'h0000, 16'h0002};
        vecs[8] = '{5'd7, 16'h8001, 16'h0000, 16'h4000};

        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        pend_op[0] = '0; pend_op[1] = '0;
        pend_x[0] = '0; pend_x[1] = '0; pend_y[0] = '0; pend_y[1] = '0;
        drive_reqs();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        model_last  = 1;
        rst_n       = 1'b0;
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op from requester 0.
        set_req(0, 5'd0, 16'h0003, 16'h0004);
        serve_one(0, 1'b0, z);
        check_eq("single_z", z, 16'h0007);

        // Tie from reset: 0, 1, 0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_last = 1;
        set_req(0, 5'd0, 16'h0100, 16'h0023);
        set_req(1, 5'd1, 16'h0050, 16'h0008);
        serve_one(0, 1'b0, z);
        check_eq("tie0_z", z, 16'h0123);
        set_req(0, 5'd4, 16'h00FF, 16'h0F0F);
        serve_one(0, 1'b0, z);
        check_eq("tie1_z", z, 16'h0048);
        serve_one(0, 1'b0, z);
        check_eq("tie2_z", z, 16'h0FF0);

        // Backpressure on requester 1 with requester 0 waiting.
        set_req(0, 5'd2, 16'h1234, 16'h00FF);
        set_req(1, 5'd3, 16'h1200, 16'h0034);
        serve_one(5, 1'b0, z);
        check_eq("bp_z", z, 16'h1234);
        serve_one(0, 1'b0, z);
        check_eq("bp_next_z", z, 16'h0034);

        // Reset during EXEC drops the op.
        set_req(0, 5'd0, 16'h0001, 16'h0001);
        drive_reqs();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("midop_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midop_reset");
        pend_v[0] = 1'b0;
        drive_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_reset_quiet", {resp0_valid, resp1_valid, busy}, 3'b000);
        end
        set_req(1, 5'd1, 16'h0009, 16'h0002);
        serve_one(1, 1'b0, z);
        check_eq("post_reset_z", z, 16'h0007);

        // Vector sweep through alternating requesters.
        for (int i = 0; i < 9; i++) begin
            set_req(i % 2, vecs[i].op, vecs[i].x, vecs[i].y);
            serve_one(0, 1'b0, z);
            check_eq($sformatf("vec%0d_z", i), z, vecs[i].z);
        end

        // Randomized traffic with random stalls and competing requests.
        for (int i = 0; i < 60; i++) begin
            if (!pend_v[0] && $urandom_range(0, 1) == 1) rand_req(0);
            if (!pend_v[1] && $urandom_range(0, 1) == 1) rand_req(1);
            if (!pend_v[0] && !pend_v[1]) rand_req($urandom_range(0, 1));
            serve_one($urandom_range(0, 3), 1'($urandom_range(0, 1)), z);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
